// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/SRAM/WB-facing signals of the memory stage
interface mem_stage_if;
  logic        EX_MEM_valid;
  logic [31:0] EX_pc;
  logic [41:0] EX_mem_bus;
  logic        MEM_allowin;
  logic [31:0] data_sram_rdata;
  logic        data_sram_data_ok;
  logic        WB_allowin;
  logic        MEM_WB_valid;
  logic [31:0] MEM_pc;
  logic [37:0] MEM_rf_bus;
  logic [38:0] MEM_fwd_bus;
  modport master (
    input  EX_MEM_valid, EX_pc, EX_mem_bus, data_sram_rdata, data_sram_data_ok, WB_allowin,
    output MEM_allowin, MEM_WB_valid, MEM_pc, MEM_rf_bus, MEM_fwd_bus
  );
  modport slave (
    output EX_MEM_valid, EX_pc, EX_mem_bus, data_sram_rdata, data_sram_data_ok, WB_allowin,
    input  MEM_allowin, MEM_WB_valid, MEM_pc, MEM_rf_bus, MEM_fwd_bus
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: load wait, data alignment and result selection between EX and WB
module mem_stage #(
  parameter logic [31:0] PC_RST = 32'h0000_0000
) (
  input logic         clk,
  input logic         resetn,
  mem_stage_if.master bus
);
  logic        mem_valid, rdata_buf_valid;
  logic [31:0] mem_pc, rdata_buf;
  logic [41:0] mem_bus;
  logic        res_from_mem, rf_we, ld_pend, ready_go, leave;
  logic [2:0]  ld_type;
  logic [4:0]  rf_waddr;
  logic [31:0] alu_result, raw, load_result, rf_wdata;
  logic [1:0]  a;
  logic [7:0]  lb;
  logic [15:0] lh;
  assign {res_from_mem, ld_type, rf_we, rf_waddr, alu_result} = mem_bus;
  assign ld_pend  = mem_valid & res_from_mem;
  assign ready_go = ~ld_pend | bus.data_sram_data_ok | rdata_buf_valid;
  assign leave    = mem_valid & ready_go & bus.WB_allowin;
  assign bus.MEM_allowin  = ~mem_valid | (ready_go & bus.WB_allowin);
  assign bus.MEM_WB_valid = mem_valid & ready_go;
  assign bus.MEM_pc       = mem_pc;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid       <= 1'b0;
      mem_pc          <= PC_RST;
      mem_bus         <= '0;
      rdata_buf       <= '0;
      rdata_buf_valid <= 1'b0;
    end else begin
      if (bus.MEM_allowin) mem_valid <= bus.EX_MEM_valid;
      if (bus.EX_MEM_valid && bus.MEM_allowin) begin
        mem_pc  <= bus.EX_pc;
        mem_bus <= bus.EX_mem_bus;
      end
      // leaving MEM wins over capture; a response while buffered is ignored
      if (leave) rdata_buf_valid <= 1'b0;
      else if (ld_pend && bus.data_sram_data_ok && !rdata_buf_valid && !bus.WB_allowin) begin
        rdata_buf       <= bus.data_sram_rdata;
        rdata_buf_valid <= 1'b1;
      end
    end
  end
  always_comb begin
    raw = rdata_buf_valid ? rdata_buf : bus.data_sram_rdata;
    a   = alu_result[1:0];
    lb  = a == 2'd0 ? raw[7:0] : a == 2'd1 ? raw[15:8] : a == 2'd2 ? raw[23:16] : raw[31:24];
    lh  = a[1] ? raw[31:16] : raw[15:0];
    load_result = ld_type == 3'b001 ? {{24{lb[7]}}, lb} :
                  ld_type == 3'b010 ? {{16{lh[15]}}, lh} :
                  ld_type == 3'b011 ? {24'b0, lb} :
                  ld_type == 3'b100 ? {16'b0, lh} : raw;
    rf_wdata = res_from_mem ? load_result : alu_result;
  end
  assign bus.MEM_rf_bus  = {rf_we, rf_waddr, rf_wdata};
  assign bus.MEM_fwd_bus = {ld_pend & ~ready_go, mem_valid & rf_we, rf_waddr, rf_wdata};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of the memory stage handshake, alignment and buffering
module tb_mem_stage;
  localparam logic [31:0] PCR = 32'h1C00_0000;
  logic clk = 1'b0, resetn = 1'b0;
  int n_cmp = 0, n_err = 0;
  mem_stage_if bus();
  mem_stage #(.PC_RST(PCR)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [41:0] mk(input logic res, input logic [2:0] ldt, input logic we,
                                      input logic [4:0] wa, input logic [31:0] alu);
    return {res, ldt, we, wa, alu};
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    bus.EX_MEM_valid = 0; bus.EX_pc = 0; bus.EX_mem_bus = 0;
    bus.data_sram_rdata = 0; bus.data_sram_data_ok = 0; bus.WB_allowin = 1;
    tick; tick;
    @(negedge clk);
    n_cmp++; if (bus.MEM_WB_valid !== 1'b0) begin n_err++; $display("FAIL rst_wbvalid got %b exp 0", bus.MEM_WB_valid); end
    n_cmp++; if (bus.MEM_allowin !== 1'b1) begin n_err++; $display("FAIL rst_allowin got %b exp 1", bus.MEM_allowin); end
    n_cmp++; if (bus.MEM_rf_bus !== 38'h0) begin n_err++; $display("FAIL rst_rfbus got %h exp 0", bus.MEM_rf_bus); end
    n_cmp++; if (bus.MEM_fwd_bus !== 39'h0) begin n_err++; $display("FAIL rst_fwdbus got %h exp 0", bus.MEM_fwd_bus); end
    n_cmp++; if (bus.MEM_pc !== PCR) begin n_err++; $display("FAIL rst_pc got %h exp %h", bus.MEM_pc, PCR); end
    tick;
    resetn = 1'b1;
  endtask

  task automatic test_alu;
    bus.EX_MEM_valid = 1; bus.EX_pc = 32'h100; bus.EX_mem_bus = mk(0, 3'b000, 1, 5'd5, 32'h1234_5678);
    bus.WB_allowin = 1;
    tick;
    bus.EX_MEM_valid = 0;
    @(negedge clk);
    n_cmp++; if (bus.MEM_WB_valid !== 1'b1) begin n_err++; $display("FAIL alu_wbvalid got %b exp 1", bus.MEM_WB_valid); end
    n_cmp++; if (bus.MEM_rf_bus !== {1'b1, 5'd5, 32'h1234_5678}) begin n_err++; $display("FAIL alu_rfbus got %h exp %h", bus.MEM_rf_bus, {1'b1, 5'd5, 32'h1234_5678}); end
    n_cmp++; if (bus.MEM_fwd_bus[38:37] !== 2'b01) begin n_err++; $display("FAIL alu_fwdflags got %b exp 01", bus.MEM_fwd_bus[38:37]); end
    n_cmp++; if (bus.MEM_pc !== 32'h100) begin n_err++; $display("FAIL alu_pc got %h exp 100", bus.MEM_pc); end
    tick;
    @(negedge clk);
    n_cmp++; if (bus.MEM_WB_valid !== 1'b0) begin n_err++; $display("FAIL alu_bubble got %b exp 0", bus.MEM_WB_valid); end
    tick;
  endtask

  task automatic test_load(input string name, input logic [2:0] ldt, input logic [1:0] a,
                           input logic [31:0] rdata, input logic [31:0] exp);
    bus.EX_MEM_valid = 1; bus.EX_pc = 32'h140; bus.EX_mem_bus = mk(1, ldt, 1, 5'd7, {30'h0000_0400, a});
    bus.WB_allowin = 1;
    tick;
    bus.EX_MEM_valid = 0; bus.data_sram_data_ok = 1; bus.data_sram_rdata = rdata;
    @(negedge clk);
    n_cmp++; if (bus.MEM_WB_valid !== 1'b1) begin n_err++; $display("FAIL %s_wbvalid got %b exp 1", name, bus.MEM_WB_valid); end
    n_cmp++; if (bus.MEM_rf_bus[31:0] !== exp) begin n_err++; $display("FAIL %s_wdata got %h exp %h", name, bus.MEM_rf_bus[31:0], exp); end
    tick;
    bus.data_sram_data_ok = 0;
  endtask

  task automatic test_load_wait;
    bus.EX_MEM_valid = 1; bus.EX_pc = 32'h180; bus.EX_mem_bus = mk(1, 3'b000, 1, 5'd3, 32'h0000_2000);
    bus.WB_allowin = 1;
    tick;
    bus.EX_MEM_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if ({bus.MEM_allowin, bus.MEM_fwd_bus[38], bus.MEM_WB_valid} !== 3'b010) begin
        n_err++; $display("FAIL wait%0d allowin/pend/wbvalid got %b exp 010", i, {bus.MEM_allowin, bus.MEM_fwd_bus[38], bus.MEM_WB_valid});
      end
      tick;
    end
    bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h5A5A_00FF;
    @(negedge clk);
    n_cmp++; if ({bus.MEM_allowin, bus.MEM_fwd_bus[38], bus.MEM_WB_valid} !== 3'b101) begin
      n_err++; $display("FAIL wait_done allowin/pend/wbvalid got %b exp 101", {bus.MEM_allowin, bus.MEM_fwd_bus[38], bus.MEM_WB_valid});
    end
    n_cmp++; if (bus.MEM_fwd_bus[31:0] !== 32'h5A5A_00FF) begin n_err++; $display("FAIL wait_fwddata got %h exp 5a5a00ff", bus.MEM_fwd_bus[31:0]); end
    tick;
    bus.data_sram_data_ok = 0;
  endtask

  task automatic test_buffered;
    bus.EX_MEM_valid = 1; bus.EX_pc = 32'h1C0; bus.EX_mem_bus = mk(1, 3'b000, 1, 5'd4, 32'h0000_3000);
    bus.WB_allowin = 1;
    tick;
    bus.EX_MEM_valid = 0; bus.WB_allowin = 0; bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    n_cmp++; if ({bus.MEM_allowin, bus.MEM_WB_valid} !== 2'b01) begin n_err++; $display("FAIL buf_resp allowin/wbvalid got %b exp 01", {bus.MEM_allowin, bus.MEM_WB_valid}); end
    tick;
    bus.data_sram_data_ok = 0; bus.data_sram_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++; if (dut.rdata_buf_valid !== 1'b1) begin n_err++; $display("FAIL buf_valid got %b exp 1", dut.rdata_buf_valid); end
    n_cmp++; if (bus.MEM_rf_bus[31:0] !== 32'hCAFE_F00D) begin n_err++; $display("FAIL buf_hold_wdata got %h exp cafef00d", bus.MEM_rf_bus[31:0]); end
    tick;
    bus.WB_allowin = 1;
    bus.EX_MEM_valid = 1; bus.EX_pc = 32'h200; bus.EX_mem_bus = mk(0, 3'b000, 1, 5'd9, 32'h0BAD_CAFE);
    @(negedge clk);
    n_cmp++; if ({bus.MEM_allowin, bus.MEM_WB_valid} !== 2'b11) begin n_err++; $display("FAIL buf_leave allowin/wbvalid got %b exp 11", {bus.MEM_allowin, bus.MEM_WB_valid}); end
    n_cmp++; if (bus.MEM_rf_bus !== {1'b1, 5'd4, 32'hCAFE_F00D}) begin n_err++; $display("FAIL buf_leave_rfbus got %h exp %h", bus.MEM_rf_bus, {1'b1, 5'd4, 32'hCAFE_F00D}); end
    tick;
    bus.EX_MEM_valid = 0;
    @(negedge clk);
    n_cmp++; if (dut.rdata_buf_valid !== 1'b0) begin n_err++; $display("FAIL buf_clear got %b exp 0", dut.rdata_buf_valid); end
    n_cmp++; if ({bus.MEM_pc, bus.MEM_rf_bus[31:0]} !== {32'h200, 32'h0BAD_CAFE}) begin
      n_err++; $display("FAIL buf_next pc/wdata got %h exp %h", {bus.MEM_pc, bus.MEM_rf_bus[31:0]}, {32'h200, 32'h0BAD_CAFE});
    end
    tick;
  endtask

  task automatic test_reset_midload;
    bus.EX_MEM_valid = 1; bus.EX_pc = 32'h240; bus.EX_mem_bus = mk(1, 3'b001, 1, 5'd6, 32'h0000_4001);
    bus.WB_allowin = 1;
    tick;
    bus.EX_MEM_valid = 0; resetn = 0;
    tick;
    resetn = 1; bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h1111_2222;
    @(negedge clk);
    n_cmp++; if (bus.MEM_WB_valid !== 1'b0) begin n_err++; $display("FAIL rml_wbvalid got %b exp 0", bus.MEM_WB_valid); end
    n_cmp++; if (bus.MEM_pc !== PCR) begin n_err++; $display("FAIL rml_pc got %h exp %h", bus.MEM_pc, PCR); end
    tick;
    bus.data_sram_data_ok = 0;
    @(negedge clk);
    n_cmp++; if ({dut.rdata_buf_valid, bus.MEM_WB_valid} !== 2'b00) begin n_err++; $display("FAIL rml_after bufvalid/wbvalid got %b exp 00", {dut.rdata_buf_valid, bus.MEM_WB_valid}); end
    tick;
  endtask

  initial begin
    test_reset;
    test_alu;
    test_load("lb",  3'b001, 2'b11, 32'h80FF_0000, 32'hFFFF_FF80);
    test_load("lbu", 3'b011, 2'b11, 32'h80FF_0000, 32'h0000_0080);
    test_load("lb1", 3'b001, 2'b01, 32'h0000_7F00, 32'h0000_007F);
    test_load("lhu", 3'b100, 2'b10, 32'hBEEF_1234, 32'h0000_BEEF);
    test_load("lh",  3'b010, 2'b10, 32'hBEEF_1234, 32'hFFFF_BEEF);
    test_load("lh0", 3'b010, 2'b00, 32'hBEEF_9234, 32'hFFFF_9234);
    test_load("lw",  3'b000, 2'b00, 32'h8765_4321, 32'h8765_4321);
    test_load("ld7", 3'b111, 2'b01, 32'hA5A5_5A5A, 32'hA5A5_5A5A);
    test_load_wait;
    test_buffered;
    test_reset_midload;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
